// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and sizing helpers for the register write arbiter.
package reg_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  // Index width for a requester count; at least one bit so degenerate sizes still elaborate.
  function automatic int idx_w(input int r);
    return (r > 1) ? $clog2(r) : 1;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request bit at or after ptr, modulo R.
module rr_picker
  import reg_arb_pkg::*;
#(
  parameter  int R  = 4,
  localparam int IW = idx_w(R)
) (
  input  logic [R-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand_s;

  // Scan from the farthest offset back to ptr so the nearest requester is written last and wins.
  always_comb begin
    found  = 1'b0;
    idx    = {IW{1'b0}};
    cand_s = ptr;
    for (int i = R - 1; i >= 0; i--) begin
      cand_s = ptr + IW'(i);
      found  = found | req[cand_s];
      idx    = req[cand_s] ? cand_s : idx;
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter driving one load/store register, with a bounded burst lock.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter  int N        = 8,
  parameter  int R        = 4,
  parameter  int MAX_LOCK = 8,
  localparam int IW       = idx_w(R),
  localparam int CW       = $clog2(MAX_LOCK + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [R-1:0]        req,
  input  logic [R-1:0]        clr_req,
  input  logic [R-1:0]        lock,
  input  logic [R-1:0][N-1:0] wdata,
  output logic [R-1:0]        gnt,
  output logic [IW-1:0]       owner,
  output logic                busy,
  output logic                reg_load,
  output logic                reg_clear,
  output logic [N-1:0]        reg_in
);

  arb_state_t    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic [R-1:0]  gnt_q, gnt_d;
  logic          busy_q, busy_d;
  logic          load_q, load_d;
  logic          clear_q, clear_d;
  logic [N-1:0]  reg_in_q, reg_in_d;

  logic [IW-1:0] pick_ptr_s;
  logic [IW-1:0] win_s;
  logic [IW-1:0] sel_s;
  logic          found_s;
  logic          stay_s;
  logic          take_s;

  // Leaving a lock restarts the search just past the owner so it drops to lowest priority.
  assign pick_ptr_s = (state_q == LOCK) ? (owner_q + IW'(1)) : ptr_q;
  assign stay_s     = (state_q == LOCK) && lock[owner_q] && (lock_cnt_q != CW'(MAX_LOCK));

  rr_picker #(
    .R(R)
  ) u_picker (
    .req  (req),
    .ptr  (pick_ptr_s),
    .found(found_s),
    .idx  (win_s)
  );

  // Next-state and next-output selection for both arbitration and locked cycles.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    gnt_d      = {R{1'b0}};
    load_d     = 1'b0;
    clear_d    = 1'b0;
    reg_in_d   = reg_in_q;
    sel_s      = win_s;
    take_s     = found_s;

    // Idle locked cycles still consume budget so a silent owner cannot starve others.
    if (stay_s) begin
      sel_s      = owner_q;
      take_s     = req[owner_q];
      state_d    = LOCK;
      lock_cnt_d = lock_cnt_q + CW'(1);
    end else if (found_s && lock[win_s] && (MAX_LOCK > 1)) begin
      state_d    = LOCK;
      lock_cnt_d = CW'(1);
    end else begin
      state_d    = ARB;
      lock_cnt_d = {CW{1'b0}};
    end

    if (take_s) begin
      gnt_d    = {{(R - 1){1'b0}}, 1'b1} << sel_s;
      owner_d  = sel_s;
      reg_in_d = wdata[sel_s];
      ptr_d    = sel_s + IW'(1);
      clear_d  = clr_req[sel_s];
      load_d   = ~clr_req[sel_s];
    end else begin
      gnt_d    = {R{1'b0}};
      owner_d  = owner_q;
      reg_in_d = reg_in_q;
      ptr_d    = ptr_q;
      clear_d  = 1'b0;
      load_d   = 1'b0;
    end

    busy_d = (state_d == LOCK);
  end

  // State and output flops; reset drops any pending grant and never pulses reg_clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ARB;
      ptr_q      <= {IW{1'b0}};
      owner_q    <= {IW{1'b0}};
      lock_cnt_q <= {CW{1'b0}};
      gnt_q      <= {R{1'b0}};
      busy_q     <= 1'b0;
      load_q     <= 1'b0;
      clear_q    <= 1'b0;
      reg_in_q   <= {N{1'b0}};
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
      gnt_q      <= gnt_d;
      busy_q     <= busy_d;
      load_q     <= load_d;
      clear_q    <= clear_d;
      reg_in_q   <= reg_in_d;
    end
  end

  assign gnt       = gnt_q;
  assign owner     = owner_q;
  assign busy      = busy_q;
  assign reg_load  = load_q;
  assign reg_clear = clear_q;
  assign reg_in    = reg_in_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed scenarios plus randomized traffic vs. a reference model.
module tb_reg_write_arbiter;

  localparam int N        = 8;
  localparam int R        = 4;
  localparam int MAX_LOCK = 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [R-1:0]        req;
  logic [R-1:0]        clr_req;
  logic [R-1:0]        lock;
  logic [R-1:0][N-1:0] wdata;
  logic [R-1:0]        gnt;
  logic [1:0]          owner;
  logic                busy;
  logic                reg_load;
  logic                reg_clear;
  logic [N-1:0]        reg_in;
  logic [N-1:0]        reg_out = 8'h00;

  int checks   = 0;
  int failures = 0;

  // Reference model state, kept as plain integers.
  int          m_ptr;
  int          m_owner;
  int          m_run;
  bit          m_locked;
  logic [R-1:0] exp_gnt;
  logic [1:0]   exp_owner;
  logic         exp_busy;
  logic         exp_load;
  logic         exp_clear;
  logic [N-1:0] exp_in;

  reg_write_arbiter #(.N(N), .R(R), .MAX_LOCK(MAX_LOCK)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .clr_req  (clr_req),
    .lock     (lock),
    .wdata    (wdata),
    .gnt      (gnt),
    .owner    (owner),
    .busy     (busy),
    .reg_load (reg_load),
    .reg_clear(reg_clear),
    .reg_in   (reg_in)
  );

  always #5 clk = ~clk;

  // Behavioural target register: synchronous load, asynchronous clear.
  always @(posedge clk or posedge reg_clear) begin
    if (reg_clear) reg_out <= 8'h00;
    else if (reg_load) reg_out <= reg_in;
  end

  task automatic model_step();
    int cand;
    int start;
    if (!rst_n) begin
      m_ptr = 0; m_owner = 0; m_run = 0; m_locked = 1'b0;
      exp_gnt = 4'b0000; exp_owner = 2'd0; exp_busy = 1'b0;
      exp_load = 1'b0; exp_clear = 1'b0; exp_in = 8'h00;
      return;
    end
    cand = -1;
    if (m_locked && lock[m_owner] && m_run < MAX_LOCK) begin
      m_run = m_run + 1;
      if (req[m_owner]) cand = m_owner;
    end else begin
      start = m_locked ? (m_owner + 1) % R : m_ptr;
      m_locked = 1'b0;
      m_run = 0;
      for (int off = 0; off < R; off++)
        if (cand < 0 && req[(start + off) % R]) cand = (start + off) % R;
      if (cand >= 0 && lock[cand] && MAX_LOCK > 1) begin
        m_locked = 1'b1;
        m_run = 1;
      end
    end
    exp_gnt = 4'b0000; exp_load = 1'b0; exp_clear = 1'b0;
    if (cand >= 0) begin
      exp_gnt   = 4'b0001 << cand;
      m_owner   = cand;
      exp_owner = 2'(cand);
      exp_in    = wdata[cand];
      m_ptr     = (cand + 1) % R;
      exp_clear = clr_req[cand];
      exp_load  = !clr_req[cand];
    end
    exp_busy = m_locked;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0; req = 4'b0000; clr_req = 4'b0000; lock = 4'b0000;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b1111; clr_req = 4'b1111; lock = 4'b1111;
    wdata = {4{8'hFF}};
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if ({gnt, owner, busy, reg_load, reg_clear, reg_in} !== 17'h0) begin
        failures++;
        $display("FAIL reset_outputs cycle %0d: got gnt=%b owner=%0d busy=%b load=%b clear=%b in=%h, required all 0",
                 c, gnt, owner, busy, reg_load, reg_clear, reg_in);
      end
    end
    rst_n = 1'b1; req = 4'b0000; clr_req = 4'b0000; lock = 4'b0000;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if ({gnt, owner, busy, reg_load, reg_clear, reg_in} !== 17'h0) begin
        failures++;
        $display("FAIL reset_release cycle %0d: got gnt=%b owner=%0d busy=%b load=%b clear=%b in=%h, required all 0",
                 c, gnt, owner, busy, reg_load, reg_clear, reg_in);
      end
    end
  endtask

  task automatic test_single_write();
    wdata[0] = 8'hA5; req = 4'b0001;
    step();
    checks++;
    if (gnt !== 4'b0001 || reg_load !== 1'b1 || reg_clear !== 1'b0 || reg_in !== 8'hA5) begin
      failures++;
      $display("FAIL single_write: got gnt=%b load=%b clear=%b in=%h, required 0001 1 0 a5",
               gnt, reg_load, reg_clear, reg_in);
    end
    req = 4'b0000;
    step();
    checks++;
    if (reg_out !== 8'hA5 || gnt !== 4'b0000 || reg_load !== 1'b0) begin
      failures++;
      $display("FAIL single_write_data: got out=%h gnt=%b load=%b, required a5 0000 0",
               reg_out, gnt, reg_load);
    end
  endtask

  task automatic test_contention();
    pulse_reset();
    for (int i = 0; i < R; i++) wdata[i] = N'($urandom);
    req = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      step();
      checks++;
      if (gnt !== (4'b0001 << (c % R)) || reg_clear !== 1'b0 || reg_in !== wdata[c % R]) begin
        failures++;
        $display("FAIL contention cycle %0d: got gnt=%b clear=%b in=%h, required gnt=%b clear=0 in=%h",
                 c, gnt, reg_clear, reg_in, 4'b0001 << (c % R), wdata[c % R]);
      end
    end
    req = 4'b0000;
    step();
  endtask

  task automatic test_back_to_back();
    wdata[3] = 8'h5A; req = 4'b1000;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (gnt !== 4'b1000 || reg_load !== 1'b1 || owner !== 2'd3) begin
        failures++;
        $display("FAIL back_to_back cycle %0d: got gnt=%b load=%b owner=%0d, required 1000 1 3",
                 c, gnt, reg_load, owner);
      end
    end
    req = 4'b0000;
    step();
  endtask

  task automatic test_clear_priority();
    wdata[2] = 8'h3C; req = 4'b0100; clr_req = 4'b0000;
    step();
    req = 4'b0000;
    step();
    checks++;
    if (reg_out !== 8'h3C) begin
      failures++;
      $display("FAIL clear_preload: got out=%h, required 3c", reg_out);
    end
    req = 4'b0100; clr_req = 4'b0100;
    step();
    checks++;
    if (reg_clear !== 1'b1 || reg_load !== 1'b0 || gnt !== 4'b0100 || reg_out !== 8'h00) begin
      failures++;
      $display("FAIL clear_priority: got clear=%b load=%b gnt=%b out=%h, required 1 0 0100 00",
               reg_clear, reg_load, gnt, reg_out);
    end
    req = 4'b0000; clr_req = 4'b1111;
    step();
    checks++;
    if (reg_clear !== 1'b0 || gnt !== 4'b0000 || reg_out !== 8'h00) begin
      failures++;
      $display("FAIL clear_without_req: got clear=%b gnt=%b out=%h, required 0 0000 00",
               reg_clear, gnt, reg_out);
    end
    clr_req = 4'b0000;
  endtask

  task automatic test_lock_cap();
    pulse_reset();
    req = 4'b0110; lock = 4'b0010; clr_req = 4'b0000;
    for (int c = 0; c < MAX_LOCK; c++) begin
      step();
      checks++;
      if (gnt !== 4'b0010 || busy !== 1'b1) begin
        failures++;
        $display("FAIL lock_hold cycle %0d: got gnt=%b busy=%b, required 0010 1", c, gnt, busy);
      end
    end
    step();
    checks++;
    if (gnt !== 4'b0100 || busy !== 1'b0) begin
      failures++;
      $display("FAIL lock_release: got gnt=%b busy=%b, required 0100 0", gnt, busy);
    end
    req = 4'b0000; lock = 4'b0000;
    step();
  endtask

  task automatic test_reset_mid_lock();
    pulse_reset();
    req = 4'b0010; lock = 4'b0010;
    for (int c = 0; c < 3; c++) step();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL midlock_busy: got busy=%b, required 1", busy);
    end
    rst_n = 1'b0;
    step();
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || owner !== 2'd0 || reg_load !== 1'b0 || reg_in !== 8'h00) begin
      failures++;
      $display("FAIL midlock_reset: got gnt=%b busy=%b owner=%0d load=%b in=%h, required all 0",
               gnt, busy, owner, reg_load, reg_in);
    end
    rst_n = 1'b1; req = 4'b1111; lock = 4'b0000;
    step();
    checks++;
    if (gnt !== 4'b0001 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midlock_ptr: got gnt=%b busy=%b, required 0001 0", gnt, busy);
    end
    req = 4'b0000;
    step();
  endtask

  task automatic test_random();
    pulse_reset();
    for (int c = 0; c < 400; c++) begin
      rst_n   = ($urandom_range(0, 49) != 0);
      req     = 4'($urandom);
      clr_req = 4'($urandom & $urandom);
      lock    = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      for (int i = 0; i < R; i++) wdata[i] = N'($urandom);
      step();
      checks++;
      if (gnt !== exp_gnt || owner !== exp_owner || busy !== exp_busy ||
          reg_load !== exp_load || reg_clear !== exp_clear || reg_in !== exp_in) begin
        failures++;
        $display("FAIL random cycle %0d: got gnt=%b owner=%0d busy=%b load=%b clear=%b in=%h, required gnt=%b owner=%0d busy=%b load=%b clear=%b in=%h",
                 c, gnt, owner, busy, reg_load, reg_clear, reg_in,
                 exp_gnt, exp_owner, exp_busy, exp_load, exp_clear, exp_in);
      end
    end
    rst_n = 1'b1; req = 4'b0000; clr_req = 4'b0000; lock = 4'b0000;
  endtask

  initial begin
    rst_n = 1'b0; req = 4'b0000; clr_req = 4'b0000; lock = 4'b0000; wdata = {4{8'h00}};
    test_reset();
    test_single_write();
    test_contention();
    test_back_to_back();
    test_clear_priority();
    test_lock_cap();
    test_reset_mid_lock();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Round-robin write arbiter sharing one load/store register among R requesters. Each cycle it selects at most one requester, forwards its data, and drives the register's `load`/`clear`/`in` pins with registered, glitch-free single-cycle pulses. A bounded lock mode lets one requester perform a burst of writes. Sits between client FSMs and a `register #(N)` instance.

## Interface
- `N`, 8: data width; must match the driven register.
- `R`, 4: number of requesters; power of 2, at least 2.
- `MAX_LOCK`, 8: maximum consecutive grants to one locked owner; at least 1.

Ports:
- `clk` input, 1 bit: the only clock; all logic on its rising edge.
- `rst_n` input, 1 bit: synchronous reset, active-low.
- `req` input, R bits: per-requester write request.
- `clr_req` input, R bits: the request is a clear, not a load; qualified by `req`.
- `lock` input, R bits: hold ownership after this grant.
- `wdata` input, R×N bits, packed `[R-1:0][N-1:0]`: per-requester write data.
- `gnt` output, R bits: one-hot grant/ack, registered.
- `owner` output, `$clog2(R)` bits: index of the current or last grantee.
- `busy` output, 1 bit: high while in LOCK state.
- `reg_load` output, 1 bit: drives register `load`.
- `reg_clear` output, 1 bit: drives register `clear`.
- `reg_in` output, N bits: drives register `in`.

## Operation
- **States:** ARB and LOCK.
  - Internal state: `ptr`, the round-robin start index; `lock_cnt`, 0..MAX_LOCK.
- **ARB:** if any `req` is high, the winner is the first set bit scanning `ptr, ptr+1, …` mod R. At the next edge:
  - `gnt[w]` goes high.
  - `owner` becomes `w`.
  - `reg_in` becomes `wdata[w]`.
  - `ptr` becomes `(w+1) mod R`.
  - If `clr_req[w]`: `reg_clear`=1 and `reg_load`=0. Otherwise `reg_load`=1. Clear wins over load.
  - If `lock[w]` is high and MAX_LOCK>1: go to LOCK with `lock_cnt`=1.
  - If no requests: `gnt`, `reg_load`, `reg_clear` are 0; `reg_in` and `owner` hold.
- **LOCK:** only `owner` is considered.
  - `req[owner]` high → grant as above and `lock_cnt`+1.
  - `req[owner]` low → idle cycle, stay in LOCK. The count still increments, so an idle owner cannot starve others.
  - **Exit:** `lock[owner]` low, or `lock_cnt` reaching MAX_LOCK. The exit cycle performs normal ARB selection among all requesters, with `ptr` = owner+1.
  - `busy` is high in LOCK, including on idle cycles.
- **Outputs:**
  - `gnt`, `reg_load` and `reg_clear` are high for exactly one cycle per accepted request.
  - All outputs come directly from flops. `reg_clear` must never glitch, because the register clears asynchronously on it.
- **Requester rule:** `req` sampled high while that requester's own `gnt` is high counts as a new request. Single-write clients drop `req` in the cycle they see `gnt`.
- **Boundaries:**
  - `ptr` wraps from R-1 to 0.
  - `clr_req` without `req` is ignored.
  - `lock` is sampled only from the winner or owner.
- **Reset:**
  - `rst_n` low at an edge sets state ARB, `ptr`=0, `lock_cnt`=0, and zeroes all outputs (`reg_in`=0, `owner`=0).
  - A grant pending at that edge is dropped.
  - `rst_n` never asserts `reg_clear`; clearing the register at reset is the integrator's responsibility.

## Timing
- Inputs are sampled at edge k. `gnt`, `reg_*` are valid from edge k until edge k+1.
- Register result:
  - Load: register `out` updates at edge k+1, a 2-edge request-to-data latency.
  - Clear: register `out` is 0 shortly after edge k (asynchronous).
- **Throughput:**
  - One write per cycle.
  - Under full contention each requester is served at least once every R cycles.
  - A locked owner holds at most MAX_LOCK consecutive cycles.

## Structure
- Package `reg_arb_pkg`:
  - `arb_state_t` enum (ARB, LOCK).
  - Localparam helper for the index width `$clog2(R)`.
- Sub-module `rr_picker #(R)`: combinational; takes `req` and `ptr`, returns `found` and winner index.
- Top level: state, `ptr`, `lock_cnt` and output flops in one `always_ff` with synchronous `rst_n`.

## Test plan
Defaults N=8, R=4, MAX_LOCK=8.
1. **Reset:** `rst_n` low 2 cycles with all inputs high → all outputs 0. Release with `req`=0 → outputs remain 0.
2. **Single write:** `req`=0001, `wdata[0]`=8'hA5 → next cycle `gnt`=0001, `reg_load`=1, `reg_in`=A5; register `out`=A5 one edge later.
3. **Contention:** `req`=1111 held 8 cycles → grants 0,1,2,3,0,1,2,3. `reg_clear`=0 throughout.
4. **Clear priority:** `req`=0100, `clr_req`=0100 while register holds 3C → `reg_clear` pulses 1 cycle, `reg_load`=0, register `out`=0.
5. **Lock cap:** requester 1 with `lock`=1 and `req`=1 continuously, requester 2 also requesting → 8 grants to 1 with `busy`=1, then forced release. Requester 2 is granted next, with `busy`=0.
6. **Reset mid-lock:** `rst_n` low in the 3rd locked cycle → next cycle state ARB, `gnt`=0, `ptr`=0.
